ysyx_25040105_exu_seq: RTL and testbench
========================================

Name: ysyx_25040105_exu_seq

Overview:
Multi-cycle execute sequencer for the single-issue core. It accepts one decoded instruction at a time from IDU, lets the combinational EXU settle, and captures alu_result/jump_addr. For loads and stores it runs the LSU request/response handshake, then retires the instruction with register writeback and a next-PC update to IFU. It also handles ebreak halt, memory-timeout error and a retired-instruction counter.

Parameters:
RESET_PC, 32'h8000_0000, value of npc out of reset
MEM_TIMEOUT, 255, max cycles waited in MEM_RESP before error halt (1..255)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
in_valid  in  1  IDU has an instruction; IDU holds all in_* fields stable until in_valid&in_ready
in_ready  out  1  retire/accept strobe; high only in WB
in_pc  in  32  instruction PC
in_cls  in  3  0 ALU, 1 JUMP, 2 BRANCH, 3 LOAD, 4 STORE, 5 EBREAK, 6-7 illegal
in_rd  in  5  destination register
in_rf_wen  in  1  instruction writes rd
in_size  in  2  memory access size (0 B, 1 H, 2 W)
in_store_data  in  32  rs2 value for stores
alu_result  in  32  EXU result (address for LOAD/STORE)
jump_addr  in  32  EXU jump/branch target
br_taken  in  1  branch condition result from EXU
mem_req_valid  out  1  LSU request valid
mem_req_ready  in  1  LSU accepts request
mem_wen  out  1  1 store, 0 load
mem_addr  out  32  access address
mem_wdata  out  32  store data
mem_size  out  2  access size
mem_resp_valid  in  1  LSU response, single-cycle pulse
mem_rdata  in  32  load data (already extended by LSU)
rf_wen  out  1  register-file write enable, one cycle
rf_waddr  out  5  write address
rf_wdata  out  32  write data
npc_valid  out  1  one-cycle next-PC strobe to IFU
npc  out  32  next PC, held between strobes
halted  out  1  sticky halt
err  out  1  sticky error (illegal class or memory timeout)
retire_cnt  out  32  retired-instruction count, wraps

Behaviour:
- All outputs are registered or Moore-decoded from state. Reset values: every output 0, except npc=RESET_PC. State returns to IDLE.
- Reset mid-instruction abandons any LSU transaction. The LSU must be reset by the same rst.
- States: IDLE, EXEC, MEM_REQ, MEM_RESP, WB, HALT.
- IDLE: if in_valid, go to EXEC. Otherwise stay.
- EXEC (exactly 1 cycle): capture res_q=alu_result, tgt_q=jump_addr, tk_q=br_taken.
  - ALU, JUMP, BRANCH -> WB.
  - LOAD, STORE -> MEM_REQ.
  - EBREAK -> HALT, err stays 0.
  - Illegal class -> HALT with err=1.
- MEM_REQ:
  - mem_req_valid=1, mem_addr=res_q, mem_wen=(cls==STORE), mem_wdata=in_store_data, mem_size=in_size. These stay stable until mem_req_ready.
  - On mem_req_valid&mem_req_ready, go to MEM_RESP and clear the timeout counter.
  - mem_resp_valid is ignored in MEM_REQ.
- MEM_RESP:
  - mem_req_valid=0.
  - On mem_resp_valid, latch rdata_q=mem_rdata and go to WB.
  - Otherwise increment the counter. When it reaches MEM_TIMEOUT, go to HALT with err=1.
  - If mem_resp_valid arrives in the same cycle the counter reaches MEM_TIMEOUT, the response wins.
- WB (exactly 1 cycle):
  - in_ready=1 and npc_valid=1.
  - rf_wen=in_rf_wen & (in_rd!=0) & cls∈{ALU,JUMP,LOAD}.
  - rf_waddr=in_rd.
  - rf_wdata=rdata_q for LOAD, else res_q (JUMP result is pc+4 from EXU).
  - npc=tgt_q for JUMP, or for BRANCH with tk_q=1; otherwise in_pc+4 (32-bit wrap).
  - retire_cnt+=1 (wraps 0xFFFF_FFFF->0).
  - Next state IDLE. No back-to-back accept from WB.
- HALT: halted=1. Absorbing until rst. in_ready=0, no further requests, retire_cnt frozen. The ebreak instruction is not counted as retired.
- Latency:
  - ALU/JUMP/BRANCH: in_valid seen in IDLE at cycle T -> EXEC T+1 -> WB T+2. Throughput is 1 instruction per 3 cycles.
  - LOAD/STORE: 3 cycles + request wait + response wait.

Test Plan:
- ALU op, alu_result=0x1234, in_rd=5, in_rf_wen=1, pc=0x8000_0000 -> WB at T+2: rf_wen=1, rf_waddr=5, rf_wdata=0x1234, npc=0x8000_0004, retire_cnt=1; in_rd=0 repeat -> rf_wen=0.
- JUMP pc=0x8000_0010, alu_result=0x8000_0014, jump_addr=0x8000_0100 -> rf_wdata=0x8000_0014, npc=0x8000_0100. BRANCH br_taken=0 -> npc=0x8000_0014, rf_wen=0.
- LOAD alu_result=0x8000_1000, mem_req_ready delayed 3 cycles, resp after 2 more with rdata=0xDEADBEEF -> request fields stable while waiting; rf_wdata=0xDEADBEEF. STORE -> mem_wen=1, mem_wdata=in_store_data, rf_wen=0.
- LOAD with no response, MEM_TIMEOUT=4 -> HALT, err=1, halted=1, no rf_wen. Response on the 4th cycle -> normal WB, err=0.
- EBREAK, then in_valid held high -> halted=1, err=0, in_ready stays 0, retire_cnt unchanged. Class 7 -> err=1.
- rst asserted in MEM_RESP -> next cycle all outputs 0, npc=0x8000_0000, retire_cnt=0. Next instruction proceeds normally.

Source files
------------

// File: rtl/ysyx_25040105_exu_seq.sv
// rtl/ysyx_25040105_exu_seq.sv - multi-cycle execute sequencer: EXEC, LSU handshake, writeback, halt
// Sequences one IDU instruction at a time through EXEC/MEM/WB with registered outputs.
module ysyx_25040105_exu_seq #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int          MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [2:0]  in_cls,
  input  logic [4:0]  in_rd,
  input  logic        in_rf_wen,
  input  logic [1:0]  in_size,
  input  logic [31:0] in_store_data,
  input  logic [31:0] alu_result,
  input  logic [31:0] jump_addr,
  input  logic        br_taken,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        npc_valid,
  output logic [31:0] npc,
  output logic        halted,
  output logic        err,
  output logic [31:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_MEM_REQ, S_MEM_RESP, S_WB, S_HALT
  } state_t;

  localparam logic [2:0] CLS_ALU    = 3'd0;
  localparam logic [2:0] CLS_JUMP   = 3'd1;
  localparam logic [2:0] CLS_BRANCH = 3'd2;
  localparam logic [2:0] CLS_LOAD   = 3'd3;
  localparam logic [2:0] CLS_STORE  = 3'd4;
  localparam logic [2:0] CLS_EBREAK = 3'd5;
  localparam logic [7:0] TMO        = MEM_TIMEOUT[7:0];

  state_t      r_state;
  logic [7:0]  r_tmo;
  logic [31:0] w_pc4;
  logic [31:0] w_exec_npc;
  logic        w_rf_wen;

  assign w_pc4 = in_pc + 32'd4;
  assign w_exec_npc = ((in_cls == CLS_JUMP) || ((in_cls == CLS_BRANCH) && br_taken))
                      ? jump_addr : w_pc4;
  // Branch/store never write rd, and x0 is never written
  assign w_rf_wen = in_rf_wen && (in_rd != 5'd0) &&
                    ((in_cls == CLS_ALU) || (in_cls == CLS_JUMP) || (in_cls == CLS_LOAD));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_tmo         <= 8'd0;
      in_ready      <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_wen       <= 1'b0;
      mem_addr      <= 32'd0;
      mem_wdata     <= 32'd0;
      mem_size      <= 2'd0;
      rf_wen        <= 1'b0;
      rf_waddr      <= 5'd0;
      rf_wdata      <= 32'd0;
      npc_valid     <= 1'b0;
      npc           <= RESET_PC;
      halted        <= 1'b0;
      err           <= 1'b0;
      retire_cnt    <= 32'd0;
    end else begin
      in_ready  <= 1'b0;
      npc_valid <= 1'b0;
      rf_wen    <= 1'b0;
      case (r_state)
        S_IDLE: if (in_valid) r_state <= S_EXEC;
        S_EXEC: begin
          case (in_cls)
            CLS_ALU, CLS_JUMP, CLS_BRANCH: begin
              r_state    <= S_WB;
              in_ready   <= 1'b1;
              npc_valid  <= 1'b1;
              rf_wen     <= w_rf_wen;
              rf_waddr   <= in_rd;
              rf_wdata   <= alu_result;
              npc        <= w_exec_npc;
              retire_cnt <= retire_cnt + 32'd1;
            end
            CLS_LOAD, CLS_STORE: begin
              r_state       <= S_MEM_REQ;
              mem_req_valid <= 1'b1;
              mem_wen       <= (in_cls == CLS_STORE);
              mem_addr      <= alu_result;
              mem_wdata     <= in_store_data;
              mem_size      <= in_size;
            end
            CLS_EBREAK: begin
              r_state <= S_HALT;
              halted  <= 1'b1;
            end
            default: begin
              r_state <= S_HALT;
              halted  <= 1'b1;
              err     <= 1'b1;
            end
          endcase
        end
        S_MEM_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            r_tmo         <= 8'd0;
            r_state       <= S_MEM_RESP;
          end
        end
        S_MEM_RESP: begin
          // A response in the timeout cycle still retires the access
          if (mem_resp_valid) begin
            r_state    <= S_WB;
            in_ready   <= 1'b1;
            npc_valid  <= 1'b1;
            rf_wen     <= w_rf_wen;
            rf_waddr   <= in_rd;
            rf_wdata   <= (in_cls == CLS_LOAD) ? mem_rdata : mem_addr;
            npc        <= w_pc4;
            retire_cnt <= retire_cnt + 32'd1;
          end else if (r_tmo + 8'd1 == TMO) begin
            r_state <= S_HALT;
            halted  <= 1'b1;
            err     <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        S_WB:    r_state <= S_IDLE;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040105_exu_seq.sv
// tb/tb_ysyx_25040105_exu_seq.sv - directed self-checking bench for the execute sequencer
// Retirement model predicts each writeback; a negedge process compares every cycle.
module tb_ysyx_25040105_exu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_pc = '0;
  logic [2:0]  in_cls = '0;
  logic [4:0]  in_rd = '0;
  logic        in_rf_wen = 1'b0;
  logic [1:0]  in_size = '0;
  logic [31:0] in_store_data = '0, alu_result = '0, jump_addr = '0;
  logic        br_taken = 1'b0;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rf_wen, npc_valid, halted, err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, npc, retire_cnt;

  always #5 clk = ~clk;

  ysyx_25040105_exu_seq #(.RESET_PC(32'h8000_0000), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_cls(in_cls), .in_rd(in_rd), .in_rf_wen(in_rf_wen), .in_size(in_size),
    .in_store_data(in_store_data), .alu_result(alu_result), .jump_addr(jump_addr),
    .br_taken(br_taken), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .npc_valid(npc_valid), .npc(npc),
    .halted(halted), .err(err), .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] npc;
    logic [31:0] retire;
  } wb_t;

  wb_t         exp_q[$];
  int          n_checks = 0, n_fail = 0;
  logic [31:0] model_retire = '0;
  logic        exp_mwen = 1'b0;
  logic [31:0] exp_maddr = '0, exp_mwdata = '0;
  logic [1:0]  exp_msize = '0;
  logic        last_wen = 1'b0;
  logic [31:0] last_wdata = '0, last_npc = '0, last_retire = '0;
  int          rc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    wb_t r;
    if (!rst) begin
      chk("npc_valid_vs_in_ready", 32'(npc_valid), 32'(in_ready));
      if (in_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_retire: got in_ready=1 expected no retire");
        end else begin
          r = exp_q.pop_front();
          chk("wb_rf_wen", 32'(rf_wen), 32'(r.wen));
          chk("wb_rf_waddr", 32'(rf_waddr), 32'(r.waddr));
          chk("wb_rf_wdata", rf_wdata, r.wdata);
          chk("wb_npc", npc, r.npc);
          chk("wb_retire_cnt", retire_cnt, r.retire);
          last_wen    = rf_wen;
          last_wdata  = rf_wdata;
          last_npc    = npc;
          last_retire = retire_cnt;
        end
      end else begin
        chk("rf_wen_outside_wb", 32'(rf_wen), 32'd0);
      end
      if (mem_req_valid) begin
        chk("mem_wen", 32'(mem_wen), 32'(exp_mwen));
        chk("mem_addr", mem_addr, exp_maddr);
        chk("mem_wdata", mem_wdata, exp_mwdata);
        chk("mem_size", 32'(mem_size), 32'(exp_msize));
      end
    end
  end

  task automatic check_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_req", {29'd0, mem_req_valid, mem_wen, 1'b0} | 32'(mem_size), 32'd0);
    chk("rst_mem_addr", mem_addr | mem_wdata, 32'd0);
    chk("rst_rf", {26'd0, rf_wen, rf_waddr} | rf_wdata, 32'd0);
    chk("rst_npc_valid", 32'(npc_valid), 32'd0);
    chk("rst_npc", npc, 32'h8000_0000);
    chk("rst_halt_err", {30'd0, halted, err}, 32'd0);
    chk("rst_retire_cnt", retire_cnt, 32'd0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;
    model_retire = '0;
  endtask

  // One instruction; resp_dly=0 means the LSU never answers, rst_at>0 resets in that MEM_RESP cycle
  task automatic run(input logic [2:0] cls, input logic [31:0] pc, input logic [4:0] rd,
                     input logic wen, input logic [1:0] size, input logic [31:0] sdata,
                     input logic [31:0] alu, input logic [31:0] jaddr, input logic tk,
                     input int req_dly, input int resp_dly, input logic [31:0] rdata,
                     input int rst_at, input bit exp_wb, output int resp_cycles);
    wb_t e;
    int  req_seen;
    bit  phase, done;
    if (exp_wb) begin
      model_retire = model_retire + 32'd1;
      e.wen    = wen && (rd != 5'd0) && (cls == 3'd0 || cls == 3'd1 || cls == 3'd3);
      e.waddr  = rd;
      e.wdata  = (cls == 3'd3) ? rdata : alu;
      e.npc    = (cls == 3'd1 || (cls == 3'd2 && tk)) ? jaddr : pc + 32'd4;
      e.retire = model_retire;
      exp_q.push_back(e);
    end
    exp_mwen = (cls == 3'd4); exp_maddr = alu; exp_mwdata = sdata; exp_msize = size;
    in_cls = cls; in_pc = pc; in_rd = rd; in_rf_wen = wen; in_size = size;
    in_store_data = sdata; alu_result = alu; jump_addr = jaddr; br_taken = tk;
    in_valid = 1'b1;
    req_seen = 0; resp_cycles = 0; phase = 0; done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk);
      #1;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      if (in_ready || halted) begin
        done = 1;
      end else if (mem_req_valid) begin
        if (req_seen == req_dly) begin
          mem_req_ready = 1'b1;
          phase = 1;
        end
        req_seen++;
      end else if (phase) begin
        resp_cycles++;
        if (resp_cycles == rst_at) begin
          rst = 1'b1;
          done = 1;
        end else if (resp_cycles == resp_dly) begin
          mem_resp_valid = 1'b1;
          mem_rdata = rdata;
        end
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_timeout: got no retire/halt expected completion within 400 cycles");
    end
    in_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_dut();

    run(3'd0, 32'h8000_0000, 5'd5, 1'b1, 2'd2, 32'd0, 32'h0000_1234, 32'd0, 1'b0, 0, 0, 32'd0, 0, 1, rc);
    chk("alu_wdata", last_wdata, 32'h0000_1234);
    chk("alu_npc", last_npc, 32'h8000_0004);
    chk("alu_retire", last_retire, 32'd1);
    chk("alu_wen", 32'(last_wen), 32'd1);
    run(3'd0, 32'h8000_0004, 5'd0, 1'b1, 2'd2, 32'd0, 32'h0000_0055, 32'd0, 1'b0, 0, 0, 32'd0, 0, 1, rc);
    chk("alu_x0_wen", 32'(last_wen), 32'd0);

    run(3'd1, 32'h8000_0010, 5'd1, 1'b1, 2'd2, 32'd0, 32'h8000_0014, 32'h8000_0100, 1'b0, 0, 0, 32'd0, 0, 1, rc);
    chk("jump_wdata", last_wdata, 32'h8000_0014);
    chk("jump_npc", last_npc, 32'h8000_0100);
    run(3'd2, 32'h8000_0010, 5'd0, 1'b0, 2'd2, 32'd0, 32'd0, 32'h8000_0200, 1'b0, 0, 0, 32'd0, 0, 1, rc);
    chk("branch_nt_npc", last_npc, 32'h8000_0014);
    chk("branch_nt_wen", 32'(last_wen), 32'd0);
    run(3'd2, 32'h8000_0014, 5'd3, 1'b1, 2'd2, 32'd0, 32'd1, 32'h8000_0040, 1'b1, 0, 0, 32'd0, 0, 1, rc);
    chk("branch_tk_npc", last_npc, 32'h8000_0040);

    run(3'd3, 32'h8000_0020, 5'd7, 1'b1, 2'd2, 32'h1111_2222, 32'h8000_1000, 32'd0, 1'b0, 3, 2, 32'hDEAD_BEEF, 0, 1, rc);
    chk("load_wdata", last_wdata, 32'hDEAD_BEEF);
    chk("load_npc", last_npc, 32'h8000_0024);
    run(3'd4, 32'h8000_0024, 5'd8, 1'b1, 2'd1, 32'hA5A5_1234, 32'h8000_1004, 32'd0, 1'b0, 0, 1, 32'd0, 0, 1, rc);
    chk("store_wen", 32'(last_wen), 32'd0);
    chk("store_retire", last_retire, 32'd7);

    run(3'd3, 32'h8000_0028, 5'd9, 1'b1, 2'd0, 32'd0, 32'h8000_2000, 32'd0, 1'b0, 0, 4, 32'h0BAD_F00D, 0, 1, rc);
    chk("late_resp_wdata", last_wdata, 32'h0BAD_F00D);
    chk("late_resp_err", 32'(err), 32'd0);
    chk("late_resp_halted", 32'(halted), 32'd0);

    run(3'd3, 32'h8000_002C, 5'd10, 1'b1, 2'd2, 32'd0, 32'h8000_3000, 32'd0, 1'b0, 1, 0, 32'd0, 2, 0, rc);
    check_reset();
    rst = 1'b0;
    model_retire = '0;
    run(3'd0, 32'h8000_0000, 5'd4, 1'b1, 2'd2, 32'd0, 32'h0000_0042, 32'd0, 1'b0, 0, 0, 32'd0, 0, 1, rc);
    chk("post_reset_retire", last_retire, 32'd1);
    chk("post_reset_wdata", last_wdata, 32'h0000_0042);

    run(3'd3, 32'h8000_0004, 5'd11, 1'b1, 2'd2, 32'd0, 32'h8000_4000, 32'd0, 1'b0, 0, 0, 32'd0, 0, 0, rc);
    chk("timeout_wait_cycles", 32'(rc), 32'd4);
    chk("timeout_halted", 32'(halted), 32'd1);
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_retire", retire_cnt, 32'd1);
    reset_dut();

    run(3'd0, 32'h8000_0000, 5'd2, 1'b1, 2'd2, 32'd0, 32'h0000_0007, 32'd0, 1'b0, 0, 0, 32'd0, 0, 1, rc);
    run(3'd5, 32'h8000_0004, 5'd0, 1'b0, 2'd2, 32'd0, 32'd0, 32'd0, 1'b0, 0, 0, 32'd0, 0, 0, rc);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("ebreak_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    chk("ebreak_halted", 32'(halted), 32'd1);
    chk("ebreak_err", 32'(err), 32'd0);
    chk("ebreak_retire", retire_cnt, 32'd1);
    chk("ebreak_mem_req", 32'(mem_req_valid), 32'd0);
    reset_dut();

    run(3'd7, 32'h8000_0000, 5'd1, 1'b1, 2'd2, 32'd0, 32'd0, 32'd0, 1'b0, 0, 0, 32'd0, 0, 0, rc);
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_halted", 32'(halted), 32'd1);
    chk("illegal_retire", retire_cnt, 32'd0);

    chk("pending_retires", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
